// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions: response codes, write-arbiter state encoding
// and default bus widths.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot winner is the first requester set
// at or above ptr+1, wrapping; the pointer register belongs to the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_wr_arbiter.sv
// Round-robin arbiter sharing one AXI-lite AW/W/B channel set among NUM_REQ
// requesters, one outstanding write at a time, all outputs registered.
module axi_lite_wr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                        i_clk,
    input  logic                        i_resetn,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    input  logic [NUM_REQ*DATA_W/8-1:0] i_strb,
    output logic [NUM_REQ-1:0]          o_gnt,
    output logic [NUM_REQ-1:0]          o_done,
    output logic [1:0]                  o_resp,
    output logic                        o_busy,
    output wr_state_t                   o_dbg_state,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [ADDR_W-1:0]           m_axi_awaddr,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [DATA_W-1:0]           m_axi_wdata,
    output logic [DATA_W/8-1:0]         m_axi_wstrb,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [1:0]                  m_axi_bresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PW     = $clog2(NUM_REQ);

    wr_state_t            state;
    logic [PW-1:0]        ptr;
    logic                 aw_done;
    logic                 w_done;
    logic [NUM_REQ-1:0]   win_oh;
    logic [PW-1:0]        win_idx;
    logic [ADDR_W-1:0]    addr_sel;
    logic [DATA_W-1:0]    data_sel;
    logic [STRB_W-1:0]    strb_sel;

    // Handshakes: a beat transfers on a rising edge where valid and ready are
    // both high; valid, once raised, stays high with stable payload until then.
    wire aw_fire = m_axi_awvalid & m_axi_awready;
    wire w_fire  = m_axi_wvalid & m_axi_wready;

    assign o_dbg_state = state;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req (i_req),
        .ptr (ptr),
        .gnt (win_oh)
    );

    always_comb begin
        win_idx  = '0;
        addr_sel = '0;
        data_sel = '0;
        strb_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) begin
                win_idx  = PW'(k);
                addr_sel = i_addr[k*ADDR_W +: ADDR_W];
                data_sel = i_data[k*DATA_W +: DATA_W];
                strb_sel = i_strb[k*STRB_W +: STRB_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state         <= ST_IDLE;
            ptr           <= PW'(NUM_REQ - 1);
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            o_gnt         <= '0;
            o_done        <= '0;
            o_resp        <= RESP_OKAY;
            o_busy        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|i_req) begin
                        ptr           <= win_idx;
                        o_gnt         <= win_oh;
                        o_busy        <= 1'b1;
                        m_axi_awaddr  <= addr_sel;
                        m_axi_wdata   <= data_sel;
                        m_axi_wstrb   <= strb_sel;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // AW and W may finish in either order or on the same edge.
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        o_resp       <= m_axi_bresp;
                        o_done       <= o_gnt;
                        m_axi_bready <= 1'b0;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done <= '0;
                    o_gnt  <= '0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Directed and randomized checks of axi_lite_wr_arbiter against a
// transaction-level round-robin model with a payload expectation queue.
module tb_axi_lite_wr_arbiter;
    import axi_lite_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int EW = AW + DW + SW;

    logic              i_clk = 1'b0;
    logic              i_resetn;
    logic [N-1:0]      i_req;
    logic [N*AW-1:0]   i_addr;
    logic [N*DW-1:0]   i_data;
    logic [N*SW-1:0]   i_strb;
    logic [N-1:0]      o_gnt;
    logic [N-1:0]      o_done;
    logic [1:0]        o_resp;
    logic              o_busy;
    wr_state_t         o_dbg_state;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [AW-1:0]     m_axi_awaddr;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [DW-1:0]     m_axi_wdata;
    logic [SW-1:0]     m_axi_wstrb;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [1:0]        m_axi_bresp;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = N - 1;
    logic [EW-1:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    axi_lite_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk         (i_clk),
        .i_resetn      (i_resetn),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .i_strb        (i_strb),
        .o_gnt         (o_gnt),
        .o_done        (o_done),
        .o_resp        (o_resp),
        .o_busy        (o_busy),
        .o_dbg_state   (o_dbg_state),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (m_axi_bresp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Winner = requested index closest to the last winner going upward.
    function automatic int model_winner(input logic [N-1:0] req);
        int best, best_d, d;
        best   = -1;
        best_d = N + 1;
        for (int j = 0; j < N; j++) begin
            d = (j - model_ptr - 1 + 2 * N) % N;
            if (((req >> j) & 1) != 0 && d < best_d) begin
                best   = j;
                best_d = d;
            end
        end
        return best;
    endfunction

    // Starts in an IDLE cycle just before the sampling edge, ends in the next
    // IDLE cycle before its sampling edge.
    task automatic run_txn(input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] resp, input bit drop, output int winner);
        int w, edges, c, mx;
        bit aw_f, w_f, b_f;
        logic [EW-1:0] e;
        w = model_winner(i_req);
        winner = w;
        if (w < 0) begin
            check("no_request", 1, 0);
            return;
        end
        exp_q.push_back({i_addr[w*AW +: AW], i_data[w*DW +: DW], i_strb[w*SW +: SW]});
        model_ptr = w;
        e = exp_q[0];
        tick();
        edges = 1;
        check("grant", 64'(o_gnt), 64'(1 << w));
        check("busy_grant", 64'(o_busy), 1);
        if (drop) begin
            i_req[w] = 1'b0;
            i_data[w*DW +: DW] = ~e[SW +: DW];
            i_addr[w*AW +: AW] = $urandom;
            i_strb[w*SW +: SW] = ~e[SW-1:0];
        end
        aw_f = 0;
        w_f  = 0;
        c    = 0;
        while (!(aw_f && w_f)) begin
            if (c >= 50) begin
                check("write_timeout", 64'(c), 0);
                break;
            end
            m_axi_awready = (c >= aw_dly);
            m_axi_wready  = (c >= w_dly);
            check("awvalid", 64'(m_axi_awvalid), 64'(!aw_f));
            check("wvalid", 64'(m_axi_wvalid), 64'(!w_f));
            check("bready_early", 64'(m_axi_bready), 0);
            if (m_axi_awvalid) check("awaddr", 64'(m_axi_awaddr), 64'(e[SW+DW +: AW]));
            if (m_axi_wvalid) begin
                check("wdata", 64'(m_axi_wdata), 64'(e[SW +: DW]));
                check("wstrb", 64'(m_axi_wstrb), 64'(e[SW-1:0]));
            end
            if (m_axi_awvalid && m_axi_awready) aw_f = 1;
            if (m_axi_wvalid && m_axi_wready) w_f = 1;
            tick();
            edges++;
            c++;
        end
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        b_f = 0;
        c   = 0;
        while (!b_f) begin
            if (c >= 50) begin
                check("resp_timeout", 64'(c), 0);
                break;
            end
            m_axi_bvalid = (c >= b_dly);
            m_axi_bresp  = m_axi_bvalid ? resp : 2'b00;
            check("bready", 64'(m_axi_bready), 1);
            check("awvalid_resp", 64'(m_axi_awvalid), 0);
            check("done_early", 64'(o_done), 0);
            if (m_axi_bvalid && m_axi_bready) b_f = 1;
            tick();
            edges++;
            c++;
        end
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        check("done_pulse", 64'(o_done), 64'(1 << w));
        check("resp", 64'(o_resp), 64'(resp));
        check("gnt_done", 64'(o_gnt), 64'(1 << w));
        check("bready_done", 64'(m_axi_bready), 0);
        void'(exp_q.pop_front());
        tick();
        edges++;
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        check("done_cleared", 64'(o_done), 0);
        check("gnt_cleared", 64'(o_gnt), 0);
        check("busy_idle", 64'(o_busy), 0);
        check("state_idle", 64'(o_dbg_state), 64'(ST_IDLE));
        check("latency", 64'(edges), 64'(mx + b_dly + 4));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 64'(o_gnt), 0);
        check({tag, "_done"}, 64'(o_done), 0);
        check({tag, "_resp"}, 64'(o_resp), 0);
        check({tag, "_busy"}, 64'(o_busy), 0);
        check({tag, "_state"}, 64'(o_dbg_state), 64'(ST_IDLE));
        check({tag, "_awvalid"}, 64'(m_axi_awvalid), 0);
        check({tag, "_wvalid"}, 64'(m_axi_wvalid), 0);
        check({tag, "_bready"}, 64'(m_axi_bready), 0);
        check({tag, "_awaddr"}, 64'(m_axi_awaddr), 0);
        check({tag, "_wdata"}, 64'(m_axi_wdata), 0);
        check({tag, "_wstrb"}, 64'(m_axi_wstrb), 0);
    endtask

    initial begin
        int win;
        int ord[6] = '{0, 1, 2, 3, 0, 1};
        logic [N-1:0] r;

        i_resetn      = 1'b0;
        i_req         = '0;
        i_addr        = '0;
        i_data        = '0;
        i_strb        = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        tick();
        tick();
        check_reset_outputs("reset");
        i_resetn = 1'b1;
        repeat (3) begin
            tick();
            check("idle_busy", 64'(o_busy), 0);
            check("idle_gnt", 64'(o_gnt), 0);
        end

        // All requesters continuously: strict rotation from requester 0.
        for (int k = 0; k < N; k++) begin
            i_addr[k*AW +: AW] = 32'h1000 + 32'(k * 4);
            i_data[k*DW +: DW] = $urandom;
            i_strb[k*SW +: SW] = 4'(k + 1);
        end
        i_req = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            run_txn(0, 0, 0, RESP_OKAY, 1'b0, win);
            check("rr_order", 64'(win), 64'(ord[t]));
        end

        // Single request, minimum latency.
        i_req = 4'b0001;
        i_addr[0 +: AW] = 32'h10;
        i_data[0 +: DW] = 32'h5;
        i_strb[0 +: SW] = 4'hF;
        run_txn(0, 0, 0, RESP_OKAY, 1'b0, win);
        i_req = '0;
        tick();
        check("single_no_regrant", 64'(o_busy), 0);

        // Late awready with immediate W, then the reverse.
        i_req = 4'b0010;
        run_txn(3, 0, 0, RESP_OKAY, 1'b0, win);
        run_txn(0, 3, 0, RESP_OKAY, 1'b0, win);

        // Late SLVERR response.
        i_req = 4'b1000;
        run_txn(0, 0, 5, RESP_SLVERR, 1'b0, win);

        // Requester 2 drops request and changes payload after grant.
        i_req = 4'b0100;
        i_data[2*DW +: DW] = 32'hCAFE_0002;
        run_txn(0, 0, 0, RESP_OKAY, 1'b1, win);
        check("drop_winner", 64'(win), 2);
        tick();
        check("drop_no_regrant", 64'(o_busy), 0);

        // Random traffic.
        for (int t = 0; t < 24; t++) begin
            r = 4'($urandom_range(1, 15));
            i_req = r;
            for (int k = 0; k < N; k++) begin
                i_addr[k*AW +: AW] = $urandom;
                i_data[k*DW +: DW] = $urandom;
                i_strb[k*SW +: SW] = 4'($urandom_range(0, 15));
            end
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), win);
        end

        // Reset while waiting for the response.
        i_req = 4'b0100;
        i_data[2*DW +: DW] = 32'h1234_5678;
        void'(model_winner(i_req));
        tick();
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        check("rst_grant", 64'(o_gnt), 4);
        tick();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        check("rst_in_resp", 64'(m_axi_bready), 1);
        tick();
        i_resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        i_req = '0;
        repeat (2) begin
            tick();
            check("midreset_no_done", 64'(o_done), 0);
        end
        i_resetn  = 1'b1;
        model_ptr = N - 1;
        exp_q.delete();
        i_req = 4'b1111;
        run_txn(0, 0, 0, RESP_OKAY, 1'b0, win);
        check("post_reset_winner", 64'(win), 0);
        i_req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
